// File: rtl/mat_mem_if.sv
// Handshake bundle between the matrix-multiply master and its memory responder:
// start/done request channel plus the host preload/readback port.
interface mat_mem_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);
  logic          req_start;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [DW-1:0] req_wdata;
  logic          req_done;
  logic [DW-1:0] req_rdata;
  logic          req_err;
  logic          busy;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ready;

  modport master (
    output req_start, req_addr, req_we, req_wdata, host_we, host_addr, host_wdata,
    input  req_done, req_rdata, req_err, busy, host_rdata, host_ready
  );

  modport slave (
    input  req_start, req_addr, req_we, req_wdata, host_we, host_addr, host_wdata,
    output req_done, req_rdata, req_err, busy, host_rdata, host_ready
  );
endinterface

// File: rtl/mat_mem_responder.sv
// Word-addressed memory slave: one request per transaction, fixed latency, one-cycle done pulse.
// A host port preloads/reads back the array while no request is pending.
module mat_mem_responder #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LATENCY   = 2
) (
  input  logic     clk,
  input  logic     rst,
  mat_mem_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(LATENCY + 1);
  localparam logic [32:0] Span = 33'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q, host_rdata_q;
  logic          err_q;
  logic [DW-1:0] mem [DEPTH];

  logic          start_now, commit;
  logic [31:0]   acc_addr;
  logic          acc_we, acc_err;
  logic [DW-1:0] acc_wdata;
  logic [32:0]   off;
  logic [AW-1:0] idx;
  logic          host_ready;

  assign start_now  = (state_q == StIdle) && bus.req_start;
  assign host_ready = (state_q == StIdle) && !bus.req_start;

  // With LATENCY==1 the response edge is also the capture edge, so use the live request.
  assign acc_addr  = start_now ? bus.req_addr  : addr_q;
  assign acc_we    = start_now ? bus.req_we    : we_q;
  assign acc_wdata = start_now ? bus.req_wdata : wdata_q;

  // Bit 32 is the borrow of addr - BASE_ADDR, so underflow also lands at or above Span.
  assign off     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign acc_err = (acc_addr[1:0] != 2'b00) || (off >= Span);
  assign idx     = off[2 +: AW];

  assign commit = (state_d == StResp) && (state_q != StResp) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_start) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY > 1) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      host_rdata_q <= mem[bus.host_addr];
      if (start_now) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q <= acc_err;
        if (!acc_we) rdata_q <= acc_err ? '0 : mem[idx];
      end
    end
  end

  // Array is not reset; a request commit and a host write can never coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (commit && acc_we && !acc_err) begin
        mem[idx] <= acc_wdata;
      end else if (bus.host_we && host_ready) begin
        mem[bus.host_addr] <= bus.host_wdata;
      end
    end
  end

  assign bus.req_done   = (state_q == StResp);
  assign bus.req_rdata  = rdata_q;
  assign bus.req_err    = err_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ready = host_ready;
endmodule

// File: tb/tb_mat_mem_responder.sv
// Randomised scoreboard bench for mat_mem_responder: requests push expected responses,
// a negedge monitor pops and compares them whenever done pulses.
module tb_mat_mem_responder;
  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_mem_if #(.DW(DW), .AW(6)) bus ();

  mat_mem_responder #(
    .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] model_rdata;
  logic          model_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    longint o;
    o = longint'({32'b0, a}) - longint'({32'b0, BASE});
    return (a % 4 != 0) || (o < 0) || (o >= 4 * DEPTH);
  endfunction

  task automatic model_apply(input logic [31:0] a, input logic we, input logic [DW-1:0] wd);
    int i;
    if (!addr_bad(a)) begin
      i = int'((a - BASE) / 4);
      if (we) model[i] = wd;
      else    model_rdata = model[i];
    end else if (!we) begin
      model_rdata = '0;
    end
    model_err = addr_bad(a);
  endtask

  // Caller is at a negedge with the DUT idle; the request is sampled on the next posedge.
  task automatic issue(input logic [31:0] a, input logic we, input logic [DW-1:0] wd);
    exp_t e;
    bus.req_start = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_wdata = wd;
    model_apply(a, we, wd);
    e.rdata = model_rdata;
    e.err   = model_err;
    e.cyc   = cyc + int'(LATENCY);
    sb.push_back(e);
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [DW-1:0] wd);
    @(negedge clk);
    issue(a, we, wd);
    @(negedge clk);
    bus.req_start = 1'b0;
    drain();
  endtask

  task automatic host_write(input int i, input logic [DW-1:0] d);
    @(negedge clk);
    bus.host_we    = 1'b1;
    bus.host_addr  = 6'(i);
    bus.host_wdata = d;
    #1 chk("host_ready_idle", bus.host_ready, 1);
    model[i] = d;
    @(negedge clk);
    bus.host_we = 1'b0;
  endtask

  task automatic host_read(input int i);
    @(negedge clk);
    bus.host_addr = 6'(i);
    @(negedge clk);
    chk("host_rdata", bus.host_rdata, model[i]);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.req_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("req_rdata", bus.req_rdata, mon_e.rdata);
        chk("req_err", bus.req_err, mon_e.err);
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [DW-1:0] old;
    int r;

    rst            = 1'b1;
    bus.req_start  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = '0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    model_rdata    = '0;
    model_err      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", bus.req_done, 0);
    chk("rst_rdata", bus.req_rdata, 0);
    chk("rst_err", bus.req_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_host_rdata", bus.host_rdata, 0);
    chk("rst_host_ready", bus.host_ready, 1);
    rst = 1'b0;

    // Preload: idx 0..17 hold their index, the rest random.
    for (int i = 0; i < int'(DEPTH); i++) host_write(i, (i < 18) ? DW'(i) : DW'($urandom));
    req(32'h14, 1'b0, '0);
    chk("t1_rdata_const", bus.req_rdata, 5);

    req(32'h20, 1'b1, 32'hDEADBEEF);
    req(32'h20, 1'b0, '0);
    chk("t2_rdata_const", bus.req_rdata, 32'hDEADBEEF);
    host_read(8);
    chk("t2_host_const", bus.host_rdata, 32'hDEADBEEF);

    req(32'h102, 1'b0, '0);
    chk("t3_err_const", bus.req_err, 1);
    chk("t3_rdata_zero", bus.req_rdata, 0);
    req(BASE + 4 * DEPTH, 1'b0, '0);
    req(BASE + 4 * DEPTH, 1'b1, 32'h12345678);
    host_read(DEPTH - 1);
    host_read(0);
    req(32'h0, 1'b0, '0);
    chk("t3_err_cleared", bus.req_err, 0);

    // Held start: one transaction every LATENCY+1 cycles.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      issue(32'(4 * k), 1'b0, '0);
      if (k < 2) begin
        repeat (LATENCY + 1) @(negedge clk);
      end else begin
        @(negedge clk);
        bus.req_start = 1'b0;
      end
    end
    drain();
    chk("t4_last_rdata", bus.req_rdata, 2);

    // Reset during WAIT aborts the store.
    @(negedge clk);
    old           = model[4];
    bus.req_start = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_start = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    chk("t5_done", bus.req_done, 0);
    chk("t5_rdata", bus.req_rdata, 0);
    chk("t5_err", bus.req_err, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_host_rdata", bus.host_rdata, 0);
    rst         = 1'b0;
    model_rdata = '0;
    model_err   = 1'b0;
    host_read(4);
    chk("t5_word_kept", bus.host_rdata, old);

    // Request and host write collide: request wins.
    @(negedge clk);
    old            = model[10];
    bus.host_we    = 1'b1;
    bus.host_addr  = 6'd10;
    bus.host_wdata = 32'h55AA55AA;
    issue(32'h28, 1'b0, '0);
    #1 chk("t6_host_ready", bus.host_ready, 0);
    @(negedge clk);
    bus.host_we   = 1'b0;
    bus.req_start = 1'b0;
    drain();
    host_read(10);
    chk("t6_word_kept", bus.host_rdata, old);

    repeat (60) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        host_write(int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end else if (r < 3) begin
        host_read(int'($urandom_range(0, DEPTH - 1)));
      end else begin
        case ($urandom_range(0, 5))
          0:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
          1:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 100);
          default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        endcase
        req(a, 1'($urandom_range(0, 1)), DW'($urandom));
      end
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
